// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter in front of one shared combinational ALU.
// Each grant's ALU result is captured into that client's one-deep response register.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_result,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_result,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  logic                  req_valid [2];
  logic                  rsp_ready [2];
  logic                  elig      [2];
  logic                  grant     [2];
  logic                  rsp_valid_q  [2];
  logic                  rsp_valid_d  [2];
  logic [DATA_WIDTH-1:0] rsp_result_q [2];
  logic [DATA_WIDTH-1:0] rsp_result_d [2];
  logic                  last_q;
  logic                  last_d;

  assign req_valid[0] = req0_valid;
  assign req_valid[1] = req1_valid;
  assign rsp_ready[0] = rsp0_ready;
  assign rsp_ready[1] = rsp1_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      // A slot is free if empty or being drained this very cycle.
      assign elig[gi] = req_valid[gi] & (~rsp_valid_q[gi] | rsp_ready[gi]);

      always_comb begin
        rsp_valid_d[gi]  = rsp_valid_q[gi];
        rsp_result_d[gi] = rsp_result_q[gi];
        if (grant[gi]) begin
          rsp_valid_d[gi]  = 1'b1;
          rsp_result_d[gi] = alu_result;
        end else if (rsp_ready[gi]) begin
          rsp_valid_d[gi]  = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_q[gi]  <= 1'b0;
          rsp_result_q[gi] <= '0;
        end else begin
          rsp_valid_q[gi]  <= rsp_valid_d[gi];
          rsp_result_q[gi] <= rsp_result_d[gi];
        end
      end
    end
  endgenerate

  // On contention the client that was not granted last wins.
  assign grant[0] = elig[0] & (~elig[1] | last_q);
  assign grant[1] = elig[1] & (~elig[0] | ~last_q);

  always_comb begin
    last_d = last_q;
    if (grant[0]) last_d = 1'b0;
    else if (grant[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  always_comb begin
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_operation = '0;
    if (grant[0]) begin
      alu_src_a     = req0_a;
      alu_src_b     = req0_b;
      alu_operation = req0_op;
    end else if (grant[1]) begin
      alu_src_a     = req1_a;
      alu_src_b     = req1_b;
      alu_operation = req1_op;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed test of alu_arbiter with a small behavioural ALU closing the loop.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_operation;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_operation(alu_operation), .alu_result(alu_result)
  );

  // Only the opcodes exercised here; anything else yields 0 like the real ALU.
  always_comb begin
    alu_result = 32'h0;
    case (alu_operation)
      4'd0:  alu_result = alu_src_a & alu_src_b;
      4'd1:  alu_result = alu_src_a | alu_src_b;
      4'd2:  alu_result = alu_src_a + alu_src_b;
      4'd5:  alu_result = alu_src_a - alu_src_b;
      4'd12: alu_result = alu_src_a ^ alu_src_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    step(); step();
    chk("reset_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_rsp1_result", rsp1_result, 32'd0);
    chk("reset_alu_op", {28'b0, alu_operation}, 32'd0);
    chk("reset_req0_ready", {31'b0, req0_ready}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single client ADD
    req0_valid = 1; req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1;
    #1;
    chk("add_req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("add_req1_ready", {31'b0, req1_ready}, 32'd0);
    chk("add_alu_op", {28'b0, alu_operation}, 32'd2);
    chk("add_alu_a", alu_src_a, 32'd5);
    step();
    req0_valid = 0;
    chk("add_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("add_rsp0_result", rsp0_result, 32'd12);
    step();
    chk("add_consumed", {31'b0, rsp0_valid}, 32'd0);

    // Fill rsp0 with 2 and hold it (last becomes 0)
    req0_valid = 1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd1; rsp0_ready = 0;
    step();
    chk("bp_fill_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("bp_fill_result", rsp0_result, 32'd2);

    // Backpressure: client 0 blocked, client 1 served 3 cycles
    req1_valid = 1; req1_op = 4'd2; req1_a = 32'd3; req1_b = 32'd4; rsp1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
      chk("bp_req1_ready", {31'b0, req1_ready}, 32'd1);
      step();
      chk("bp_rsp0_hold", rsp0_result, 32'd2);
      chk("bp_rsp1_result", rsp1_result, 32'd7);
    end

    // Release + consume-and-refill: client 0 wins the same cycle
    rsp0_ready = 1; req0_op = 4'd0; req0_a = 32'hC; req0_b = 32'hA;
    #1;
    chk("release_req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("release_req1_ready", {31'b0, req1_ready}, 32'd0);
    step();
    chk("refill_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("refill_rsp0_result", rsp0_result, 32'd8);

    // Illegal opcode on client 1
    req0_valid = 0; req1_op = 4'd14; req1_a = 32'd5; req1_b = 32'd5;
    #1;
    chk("illegal_req1_ready", {31'b0, req1_ready}, 32'd1);
    chk("illegal_alu_op", {28'b0, alu_operation}, 32'd14);
    step();
    chk("illegal_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("illegal_rsp1_result", rsp1_result, 32'd0);
    chk("illegal_rsp0_drained", {31'b0, rsp0_valid}, 32'd0);

    // Idle: nothing granted, nothing changes
    req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("idle_alu_a", alu_src_a, 32'd0);
    chk("idle_alu_b", alu_src_b, 32'd0);
    chk("idle_alu_op", {28'b0, alu_operation}, 32'd0);
    chk("idle_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    step();
    chk("idle_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("idle_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);

    // Reset mid-stream with rsp0 full (last becomes 0 before reset)
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'h30; req0_b = 32'h03; rsp1_ready = 1;
    step();
    req0_valid = 0;
    chk("pre_rst_rsp0_result", rsp0_result, 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("async_rst_rsp0_result", rsp0_result, 32'd0);
    chk("async_rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Contention after reset: 0,1,0,1
    req0_valid = 1; req0_op = 4'd5;  req0_a = 32'd10;  req0_b = 32'd3;
    req1_valid = 1; req1_op = 4'd12; req1_a = 32'hF0;  req1_b = 32'hFF;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_req0_ready", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_req1_ready", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      if (i % 2 == 0) chk("cont_rsp0_result", rsp0_result, 32'd7);
      else            chk("cont_rsp1_result", rsp1_result, 32'h0F);
    end
    req0_valid = 0; req1_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
